// File: rtl/imm_decode_stage.sv
// ---------------------------------------------------------------------------
// imm_decode_stage
//
// Registered, valid/ready immediate-decode stage for an RV32I/RV64I front end.
// Each accepted instruction is decoded from its opcode into a one-hot format,
// an XLEN-wide sign-extended immediate and an illegal flag. The decoded result
// is registered and presented one cycle later.
//
// SKID = 1 : output register plus one skid entry. o_ready comes from a flop.
// SKID = 0 : single output register. o_ready = !o_valid || i_ready.
//
// Handshake rules:
//   An input transfer happens on a rising edge where i_valid && o_ready.
//   An output transfer happens on a rising edge where o_valid && i_ready.
//   While o_valid && !i_ready, all o_* result fields are held stable.
//   i_flush empties the stage on the next edge. An input offered in the flush
//   cycle is dropped. An output taken in the flush cycle counts as delivered.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_valid      upstream instruction valid
//   o_ready      stage can accept an instruction this cycle
//   i_inst       instruction word
//   i_flush      synchronous flush of all held entries
//   o_valid      decoded result valid
//   i_ready      downstream accepts the result this cycle
//   o_inst       instruction word travelling with its result
//   o_format     one-hot format [0]R [1]I [2]S [3]B [4]U [5]J, zero if illegal
//   o_immediate  sign-extended immediate, XLEN bits
//   o_illegal    opcode outside RV32I base set (including i_inst[1:0] != 2'b11)
//   o_dbg_state  current occupancy state (0 EMPTY, 1 FULL1, 2 FULL2)
// ---------------------------------------------------------------------------
module imm_decode_stage #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_inst,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [31:0]     o_inst,
  output logic [5:0]      o_format,
  output logic [XLEN-1:0] o_immediate,
  output logic            o_illegal,
  output logic [1:0]      o_dbg_state
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL1 = 2'd1,
    S_FULL2 = 2'd2
  } state_t;

  // One decoded entry: {inst, format, immediate, illegal}
  localparam int DW = 32 + 6 + XLEN + 1;

  // -------------------------------------------------------------------------
  // Decode (ahead of the registers, so both entries hold decoded results)
  // -------------------------------------------------------------------------
  logic [5:0]      w_fmt;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_illegal;
  logic [DW-1:0]   w_dec;

  always_comb begin
    w_fmt   = 6'b000000;
    w_imm32 = 32'h0000_0000;
    case (i_inst[6:0])
      7'b0110111, 7'b0010111: begin // LUI, AUIPC
        w_fmt   = 6'b010000;
        w_imm32 = {i_inst[31:12], 12'h000};
      end
      7'b1101111: begin // JAL
        w_fmt   = 6'b100000;
        w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                   i_inst[30:21], 1'b0};
      end
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: begin
        w_fmt   = 6'b000010; // JALR, LOAD, OP-IMM, FENCE, SYSTEM
        w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
      end
      7'b0100011: begin // STORE
        w_fmt   = 6'b000100;
        w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      end
      7'b1100011: begin // BRANCH
        w_fmt   = 6'b001000;
        w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                   i_inst[11:8], 1'b0};
      end
      7'b0110011: begin // OP
        w_fmt   = 6'b000001;
      end
      default: begin
        w_fmt   = 6'b000000;
        w_imm32 = 32'h0000_0000;
      end
    endcase
  end

  // Every legal opcode sets exactly one format bit; the listed opcodes all end
  // in 2'b11, so a bad i_inst[1:0] also lands here.
  assign w_illegal = (w_fmt == 6'b000000);
  assign w_imm     = XLEN'($signed(w_imm32));
  assign w_dec     = {i_inst, w_fmt, w_imm, w_illegal};

  // -------------------------------------------------------------------------
  // Occupancy FSM
  // -------------------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_out;
  logic [DW-1:0] r_skid;
  logic          w_in_xfer;
  logic          w_out_xfer;
  logic          w_load_out_dec;
  logic          w_load_out_skid;
  logic          w_load_skid;

  assign o_valid    = (r_state != S_EMPTY);
  assign w_in_xfer  = i_valid && o_ready;
  assign w_out_xfer = o_valid && i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_load_out_dec  = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    if (i_flush) begin
      // Input in this cycle is dropped; an output taken now is already gone.
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            w_load_out_dec = 1'b1;
            w_state_nxt    = S_FULL1;
          end
        end
        S_FULL1: begin
          if (w_in_xfer && w_out_xfer) begin
            w_load_out_dec = 1'b1;
          end else if (w_out_xfer) begin
            w_state_nxt = S_EMPTY;
          end else if (w_in_xfer) begin
            // Only reachable with SKID=1: o_ready was still high from the flop.
            w_load_skid = 1'b1;
            w_state_nxt = S_FULL2;
          end
        end
        S_FULL2: begin
          if (w_out_xfer) begin
            w_load_out_skid = 1'b1;
            w_state_nxt     = S_FULL1;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Data registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out  <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_out_dec) begin
        r_out <= w_dec;
      end else if (w_load_out_skid) begin
        r_out <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_dec;
      end
    end
  end

  assign {o_inst, o_format, o_immediate, o_illegal} = r_out;
  assign o_dbg_state = r_state;

  // -------------------------------------------------------------------------
  // Ready generation
  // -------------------------------------------------------------------------
  generate
    if (SKID != 0) begin : g_skid
      logic r_ready;
      // Registered ready: low exactly while the skid entry is occupied.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_ready <= 1'b1;
        end else begin
          r_ready <= (w_state_nxt != S_FULL2);
        end
      end
      assign o_ready = r_ready;
    end else begin : g_noskid
      assign o_ready = !o_valid || i_ready;
    end
  endgenerate

endmodule
